fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage: owns the PC, reads a 1-cycle-latency
//             ROM and sequences FETCH/LATCH/DECODE/EXECUTE with jump, stall
//             and HALT handling. Optional macro FETCH_COUNT_EN adds a 32-bit
//             retired-instruction counter output (retiredCount).
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned RESET_PC    = 0,
  parameter logic [3:0]  HALT_OPCODE = 4'b1111
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] imemAddr,
  input  logic [31:0]           imemData,
  input  logic                  stall,
  input  logic                  jumpTaken,
  input  logic [ADDR_WIDTH-1:0] jumpTarget,
  input  logic                  resume,
  output logic [31:0]           instruction,
  output logic                  instrValid,
  output logic [ADDR_WIDTH-1:0] pc,
`ifdef FETCH_COUNT_EN
  output logic [31:0]           retiredCount,
`endif
  output logic                  halted
);

  localparam logic [ADDR_WIDTH-1:0] c_RESET_PC = ADDR_WIDTH'(RESET_PC);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_LATCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALTED  = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic [ADDR_WIDTH-1:0]   w_pc_next;
  logic [31:0]             r_instr;
  logic [31:0]             w_instr_next;
  logic                    r_valid;
  logic                    w_valid_next;
  logic                    w_retire;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= c_RESET_PC;
      r_instr <= 32'h0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_instr <= w_instr_next;
      r_valid <= w_valid_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_instr_next = r_instr;
    w_valid_next = r_valid;
    w_retire     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_valid_next = 1'b0;
        w_state_next = S_LATCH;
      end
      S_LATCH: begin
        w_instr_next = imemData;
        w_valid_next = 1'b1;
        w_state_next = S_DECODE;
      end
      S_DECODE: begin
        w_state_next = (r_instr[31:28] == HALT_OPCODE) ? S_HALTED : S_EXECUTE;
      end
      S_EXECUTE: begin
        // Stall dominates: a jump offered during a stall is simply dropped.
        if (!stall) begin
          w_retire     = 1'b1;
          w_pc_next    = jumpTaken ? jumpTarget : r_pc + 1'b1;
          w_valid_next = 1'b0;
          w_state_next = S_FETCH;
        end
      end
      S_HALTED: begin
        if (resume) begin
          w_retire     = 1'b1;
          w_pc_next    = r_pc + 1'b1;
          w_valid_next = 1'b0;
          w_state_next = S_FETCH;
        end
      end
      default: begin
        w_state_next = S_FETCH;
      end
    endcase
  end

`ifdef FETCH_COUNT_EN
  logic [31:0] r_retired;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_retired <= 32'h0;
    end else if (w_retire) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign retiredCount = r_retired;
`else
  logic w_retire_unused;
  assign w_retire_unused = w_retire;
`endif

  assign imemAddr    = r_pc;
  assign pc          = r_pc;
  assign instruction = r_instr;
  assign instrValid  = r_valid;
  assign halted      = (r_state == S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Randomized self-checking bench for fetch_unit with a
//             per-instruction reference model and a behavioural ROM.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  imemAddr;
  logic [31:0] imemData;
  logic        stall;
  logic        jumpTaken;
  logic [9:0]  jumpTarget;
  logic        resume;
  logic [31:0] instruction;
  logic        instrValid;
  logic [9:0]  pc;
  logic        halted;
`ifdef FETCH_COUNT_EN
  logic [31:0] retiredCount;
`endif

  fetch_unit #(.ADDR_WIDTH(10), .RESET_PC(0), .HALT_OPCODE(4'b1111)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .imemAddr    (imemAddr),
    .imemData    (imemData),
    .stall       (stall),
    .jumpTaken   (jumpTaken),
    .jumpTarget  (jumpTarget),
    .resume      (resume),
    .instruction (instruction),
    .instrValid  (instrValid),
    .pc          (pc),
`ifdef FETCH_COUNT_EN
    .retiredCount(retiredCount),
`endif
    .halted      (halted)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [0:1023];
  always @(posedge clk) imemData <= rom[imemAddr];

  int          n_checks = 0;
  int          n_errors = 0;
  logic [9:0]  m_pc;
  int unsigned m_ret;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic noise();
    stall      = 1'($urandom);
    jumpTaken  = 1'($urandom);
    jumpTarget = 10'($urandom);
    resume     = 1'($urandom);
  endtask

  task automatic check_count();
`ifdef FETCH_COUNT_EN
    chk("retired", retiredCount, m_ret);
`endif
  endtask

  // One complete instruction, entered and left at the negedge of a FETCH cycle.
  task automatic run_instr(input int nstall, input bit jmp, input logic [9:0] tgt,
                           input bool_stall_jump);
    logic [31:0] exp_instr;
    exp_instr = rom[m_pc];
    chk("fetch_addr", 32'(imemAddr), 32'(m_pc));
    chk("fetch_valid", 32'(instrValid), 32'd0);
    chk("fetch_halted", 32'(halted), 32'd0);
    noise();
    @(negedge clk);
    chk("latch_valid", 32'(instrValid), 32'd0);
    noise();
    @(negedge clk);
    chk("decode_instr", instruction, exp_instr);
    chk("decode_valid", 32'(instrValid), 32'd1);
    chk("decode_pc", 32'(pc), 32'(m_pc));
    noise();
    @(negedge clk);
    if (exp_instr[31:28] == 4'hF) begin
      chk("halt_enter", 32'(halted), 32'd1);
      for (int i = 0; i < 20; i++) begin
        stall = 1'($urandom); jumpTaken = 1'($urandom);
        jumpTarget = 10'($urandom); resume = 1'b0;
        @(negedge clk);
        chk("halt_pc", 32'(pc), 32'(m_pc));
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_valid", 32'(instrValid), 32'd1);
      end
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
      m_pc = m_pc + 10'd1;
      m_ret++;
    end else begin
      chk("exec_halted", 32'(halted), 32'd0);
      for (int i = 0; i < nstall; i++) begin
        stall = 1'b1; resume = 1'($urandom);
        jumpTaken  = bool_stall_jump ? 1'b1 : 1'($urandom);
        jumpTarget = bool_stall_jump ? 10'd50 : 10'($urandom);
        @(negedge clk);
        chk("stall_pc", 32'(pc), 32'(m_pc));
        chk("stall_instr", instruction, exp_instr);
      end
      stall = 1'b0; jumpTaken = jmp; jumpTarget = tgt; resume = 1'($urandom);
      @(negedge clk);
      m_pc = jmp ? tgt : m_pc + 10'd1;
      m_ret++;
    end
    check_count();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = {1'b0, 31'($urandom)};
    rom[0] = 32'h00000001;
    rom[1] = 32'h10000000;
    rom[2] = 32'h20000001;
    rom[5] = 32'hF0000000;
    reset = 1'b1; stall = 1'b0; jumpTaken = 1'b0; jumpTarget = '0; resume = 1'b0;
    m_pc = 10'd0; m_ret = 0;
    repeat (3) @(negedge clk);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_addr", 32'(imemAddr), 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_valid", 32'(instrValid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    check_count();
    reset = 1'b0;

    run_instr(0, 1'b0, 10'd0, 1'b0);
    run_instr(0, 1'b0, 10'd0, 1'b0);
    run_instr(0, 1'b0, 10'd0, 1'b0);
    run_instr(0, 1'b1, 10'd200, 1'b0);  // pc 3 -> 200
    run_instr(3, 1'b0, 10'd0, 1'b1);    // stalled jump to 50 must be dropped
    run_instr(0, 1'b1, 10'd4, 1'b0);    // 201 -> 4
    run_instr(2, 1'b0, 10'd0, 1'b0);    // 4 -> 5
    run_instr(0, 1'b0, 10'd0, 1'b0);    // halt at 5, resume -> 6
    run_instr(0, 1'b1, 10'h3FF, 1'b0);  // 6 -> 3FF
    run_instr(1, 1'b0, 10'd0, 1'b0);    // 3FF wraps to 0
    chk("wrap_pc", 32'(m_pc), 32'd0);

    for (int k = 0; k < 40; k++) begin
      bit          j;
      logic [9:0]  t;
      j = ($urandom_range(3) == 0);
      t = (k % 7 == 0) ? 10'd5 : 10'($urandom);
      run_instr(int'($urandom_range(3)), j, t, 1'b0);
    end

    // Reset during LATCH discards the instruction in flight.
    noise();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_pc", 32'(pc), 32'd0);
    chk("mid_rst_valid", 32'(instrValid), 32'd0);
    chk("mid_rst_halted", 32'(halted), 32'd0);
    m_pc = 10'd0; m_ret = 0;
    check_count();
    reset = 1'b0;
    run_instr(0, 1'b0, 10'd0, 1'b0);
    run_instr(2, 1'b0, 10'd0, 1'b0);
    run_instr(0, 1'b0, 10'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
